pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
//  Next-generation control unit for the 5-stage pipeline. Decodes the ID-stage opcode and carries control bits
//  through the ID/EX, EX/MEM and MEM/WB registers. Adds load-use hazard stalls, branch flush, a global memory
//  stall freeze and an optional extended decode mode. Sits between the IF/ID register and the datapath stages.
// PARAMETERS
//  REG_ADDR_W  5  register-index width (rs1/rs2/rd)
//  ALUOP_W     2  ALUOp width, minimum 2
//  EXT_DECODE  0  1 = also decode jal (1101111) and lui (0110111)
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           synchronous, active-high reset
//  id_valid       in   1           IF/ID holds a real instruction
//  id_opcode      in   7           instr[6:0] in ID
//  id_rs1         in   REG_ADDR_W  source 1 index
//  id_rs2         in   REG_ADDR_W  source 2 index
//  id_rd          in   REG_ADDR_W  destination index
//  ex_branch_taken in  1           branch resolved taken in EX this cycle
//  mem_stall      in   1           data memory not ready; freeze pipeline
//  id_illegal     out  1           comb: id_valid and opcode not in decode table
//  stall_if_id    out  1           comb: hold PC and IF/ID
//  flush_if_id    out  1           comb: zero IF/ID valid next edge
//  ex_regwrite, ex_alusrc, ex_memwrite, ex_memread, ex_memtoreg, ex_branch, ex_jump  out 1 each
//  ex_aluop       out  ALUOP_W     ALU op class in EX
//  ex_rd          out  REG_ADDR_W  ; ex_valid out 1
//  mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg, mem_valid  out 1 each ; mem_rd out REG_ADDR_W
//  wb_regwrite, wb_memtoreg, wb_valid  out 1 each ; wb_rd out REG_ADDR_W
// BEHAVIOUR
//  Decode (comb) {RegWrite,ALUSrc,MemWrite,MemRead,MemtoReg,Branch,Jump,ALUOp}; uses_rs1/uses_rs2:
//   0110011 R  : 1,0,0,0,0,0,0,10  rs1,rs2 | 0010011 I : 1,1,0,0,0,0,0,10  rs1
//   0000011 lw : 1,1,0,1,1,0,0,00  rs1     | 0100011 sw: 0,1,1,0,0,0,0,00  rs1,rs2
//   1100011 beq: 0,0,0,0,0,1,0,01  rs1,rs2
//   EXT_DECODE=1: 1101111 jal: 1,0,0,0,0,0,1,00 none | 0110111 lui: 1,1,0,0,0,0,0,11 none
//   Other opcode, or ext opcode with EXT_DECODE=0: all zero, id_illegal=id_valid. ALUOp zero-extended to ALUOP_W.
//   Any control bit is gated by id_valid; id_valid=0 gives all-zero controls and no hazard.
//  RegWrite with id_rd==0 is forced to 0 at decode.
//  load_use = ex_valid & ex_memread & ex_rd!=0 & id_valid &
//             ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
//  Priority each cycle, highest first:
//   1 rst: all registered outputs 0 (valids 0, rd 0, ALUOp 0). Any op in flight is discarded.
//   2 mem_stall: all three stage registers hold; stall_if_id=1, flush_if_id=0 (even if branch/load_use).
//   3 ex_branch_taken: ID/EX loads bubble (all 0); flush_if_id=1; stall_if_id=0; EX->MEM advances normally.
//   4 load_use: ID/EX loads bubble; stall_if_id=1; EX->MEM, MEM->WB advance.
//   5 normal: ID/EX <= decode, ID/EX->EX/MEM->MEM/WB each advance one stage.
//  Latency: ID decode visible on ex_* 1 cycle later, mem_* 2, wb_* 3 (no stalls).
//  Bubble = valid 0 plus all control bits 0. Stage regs carry only control, rd and valid.
//  stall_if_id/flush_if_id/id_illegal are combinational, not registered. They are 0 during rst.
//  A single load-use stall lasts exactly 1 cycle: after the bubble, ex_memread=0.
// TESTING
//  T1 reset: rst=1 for 2 clk with id_valid=1, opcode 0110011 -> every ex_/mem_/wb_ output 0; rst low -> R decodes next edge.
//  T2 stream R,I,lw,sw,beq (rd=1..5, no deps) -> ex_* match the table 1 cycle later; wb_regwrite seq 1,1,1,0,0 at +3.
//  T3 lw x5 then R rs2=x5 -> stall_if_id=1 for 1 cycle; ex_valid=0 that cycle+1; R reaches EX 1 cycle late.
//  T4 ex_branch_taken=1 concurrent with load_use -> flush_if_id=1, stall_if_id=0, ID/EX bubble.
//  T5 mem_stall=1 for 3 cycles mid-stream -> all ex_/mem_/wb_ held, stall_if_id=1; resume with no loss/dup.
//  T6 EXT_DECODE=0 vs 1: opcode 1101111 -> id_illegal=1 with zero ctrl vs ex_jump=1, ex_regwrite=1; rd=0 -> regwrite 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : ID-stage decode plus ID/EX, EX/MEM, MEM/WB control pipeline
//               with load-use stall, branch flush and memory-stall freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter bit EXT_DECODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  output logic                  id_illegal,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  ex_regwrite,
  output logic                  ex_alusrc,
  output logic                  ex_memwrite,
  output logic                  ex_memread,
  output logic                  ex_memtoreg,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_valid,
  output logic                  mem_regwrite,
  output logic                  mem_memwrite,
  output logic                  mem_memread,
  output logic                  mem_memtoreg,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;

  logic       w_rw, w_as, w_mw, w_mr, w_mtr, w_br, w_jmp;
  logic [1:0] w_aluop2;
  logic       w_use1, w_use2, w_known;
  logic       w_load_use, w_bubble;

  always_comb begin
    w_rw     = 1'b0;
    w_as     = 1'b0;
    w_mw     = 1'b0;
    w_mr     = 1'b0;
    w_mtr    = 1'b0;
    w_br     = 1'b0;
    w_jmp    = 1'b0;
    w_aluop2 = 2'b00;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_known  = 1'b0;
    case (id_opcode)
      c_OP_R:   begin w_known = 1'b1; w_rw = 1'b1; w_aluop2 = 2'b10; w_use1 = 1'b1; w_use2 = 1'b1; end
      c_OP_I:   begin w_known = 1'b1; w_rw = 1'b1; w_as = 1'b1; w_aluop2 = 2'b10; w_use1 = 1'b1; end
      c_OP_LW:  begin w_known = 1'b1; w_rw = 1'b1; w_as = 1'b1; w_mr = 1'b1; w_mtr = 1'b1; w_use1 = 1'b1; end
      c_OP_SW:  begin w_known = 1'b1; w_as = 1'b1; w_mw = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      c_OP_BEQ: begin w_known = 1'b1; w_br = 1'b1; w_aluop2 = 2'b01; w_use1 = 1'b1; w_use2 = 1'b1; end
      c_OP_JAL: if (EXT_DECODE) begin w_known = 1'b1; w_rw = 1'b1; w_jmp = 1'b1; end
      c_OP_LUI: if (EXT_DECODE) begin w_known = 1'b1; w_rw = 1'b1; w_as = 1'b1; w_aluop2 = 2'b11; end
      default:  ;
    endcase
  end

  // Only rs indices the instruction actually reads can create a load-use hazard.
  assign w_load_use = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                      ((w_use1 & (id_rs1 == ex_rd)) | (w_use2 & (id_rs2 == ex_rd)));
  assign w_bubble   = ex_branch_taken | w_load_use;

  assign id_illegal  = ~rst & id_valid & ~w_known;
  assign stall_if_id = ~rst & (mem_stall | (~ex_branch_taken & w_load_use));
  assign flush_if_id = ~rst & ~mem_stall & ex_branch_taken;

  logic                  ex_rw_d, ex_as_d, ex_mw_d, ex_mr_d, ex_mtr_d, ex_br_d, ex_jmp_d, ex_valid_d;
  logic [ALUOP_W-1:0]    ex_aluop_d;
  logic [REG_ADDR_W-1:0] ex_rd_d;
  logic                  w_take;

  assign w_take     = id_valid & ~w_bubble;
  assign ex_valid_d = w_take;
  assign ex_rw_d    = w_take & w_rw & (id_rd != '0);
  assign ex_as_d    = w_take & w_as;
  assign ex_mw_d    = w_take & w_mw;
  assign ex_mr_d    = w_take & w_mr;
  assign ex_mtr_d   = w_take & w_mtr;
  assign ex_br_d    = w_take & w_br;
  assign ex_jmp_d   = w_take & w_jmp;
  assign ex_aluop_d = w_take ? ALUOP_W'(w_aluop2) : '0;
  assign ex_rd_d    = w_take ? id_rd : '0;

  logic                  ex_rw_q, ex_as_q, ex_mw_q, ex_mr_q, ex_mtr_q, ex_br_q, ex_jmp_q, ex_valid_q;
  logic [ALUOP_W-1:0]    ex_aluop_q;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic                  mem_rw_q, mem_mw_q, mem_mr_q, mem_mtr_q, mem_valid_q;
  logic                  wb_rw_q, wb_mtr_q, wb_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rw_q <= 1'b0; ex_as_q <= 1'b0; ex_mw_q <= 1'b0; ex_mr_q <= 1'b0;
      ex_mtr_q <= 1'b0; ex_br_q <= 1'b0; ex_jmp_q <= 1'b0; ex_valid_q <= 1'b0;
      ex_aluop_q <= '0; ex_rd_q <= '0;
      mem_rw_q <= 1'b0; mem_mw_q <= 1'b0; mem_mr_q <= 1'b0; mem_mtr_q <= 1'b0;
      mem_valid_q <= 1'b0; mem_rd_q <= '0;
      wb_rw_q <= 1'b0; wb_mtr_q <= 1'b0; wb_valid_q <= 1'b0; wb_rd_q <= '0;
    end else if (!mem_stall) begin
      ex_rw_q <= ex_rw_d; ex_as_q <= ex_as_d; ex_mw_q <= ex_mw_d; ex_mr_q <= ex_mr_d;
      ex_mtr_q <= ex_mtr_d; ex_br_q <= ex_br_d; ex_jmp_q <= ex_jmp_d; ex_valid_q <= ex_valid_d;
      ex_aluop_q <= ex_aluop_d; ex_rd_q <= ex_rd_d;
      mem_rw_q <= ex_rw_q; mem_mw_q <= ex_mw_q; mem_mr_q <= ex_mr_q; mem_mtr_q <= ex_mtr_q;
      mem_valid_q <= ex_valid_q; mem_rd_q <= ex_rd_q;
      wb_rw_q <= mem_rw_q; wb_mtr_q <= mem_mtr_q; wb_valid_q <= mem_valid_q; wb_rd_q <= mem_rd_q;
    end
  end

  assign ex_regwrite  = ex_rw_q;
  assign ex_alusrc    = ex_as_q;
  assign ex_memwrite  = ex_mw_q;
  assign ex_memread   = ex_mr_q;
  assign ex_memtoreg  = ex_mtr_q;
  assign ex_branch    = ex_br_q;
  assign ex_jump      = ex_jmp_q;
  assign ex_aluop     = ex_aluop_q;
  assign ex_rd        = ex_rd_q;
  assign ex_valid     = ex_valid_q;
  assign mem_regwrite = mem_rw_q;
  assign mem_memwrite = mem_mw_q;
  assign mem_memread  = mem_mr_q;
  assign mem_memtoreg = mem_mtr_q;
  assign mem_valid    = mem_valid_q;
  assign mem_rd       = mem_rd_q;
  assign wb_regwrite  = wb_rw_q;
  assign wb_memtoreg  = wb_mtr_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;

endmodule
`default_nettype wire
